// File: rtl/slot_encoder.sv
// One-hot slot loader: places data into one of four slots over a 3-edge load.
// Define SLOT_ENCODER_ROTATE_EN to enable slot rotation on shift in HOLD.
module slot_encoder #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       idx_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift,
    output logic [WIDTH-1:0] A1,
    output logic [WIDTH-1:0] A2,
    output logic [WIDTH-1:0] A3,
    output logic [WIDTH-1:0] A4,
    output logic [1:0]       idx_out,
    output logic             busy,
    output logic             valid,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] slot_q [4];
    logic [WIDTH-1:0] slot_d [4];
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       cap_idx_q, cap_idx_d;
    logic [WIDTH-1:0] cap_data_q, cap_data_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

`ifndef SLOT_ENCODER_ROTATE_EN
    logic unused_shift;
    assign unused_shift = shift;
`endif

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        idx_d      = idx_q;
        cap_idx_d  = cap_idx_q;
        cap_data_d = cap_data_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE, HOLD: begin
                if (start && (data_in != '0)) begin
                    cap_idx_d  = idx_in;
                    cap_data_d = data_in;
                    for (int i = 0; i < 4; i++) slot_d[i] = '0;
                    busy_d     = 1'b1;
                    valid_d    = 1'b0;
                    state_d    = CLEAR;
                end else begin
                    err_d = start;
`ifdef SLOT_ENCODER_ROTATE_EN
                    // A rejected start does not block a rotation
                    if ((state_q == HOLD) && shift) begin
                        slot_d[1] = slot_q[0];
                        slot_d[2] = slot_q[1];
                        slot_d[3] = slot_q[2];
                        slot_d[0] = slot_q[3];
                        idx_d     = idx_q + 2'd1;
                    end
`endif
                end
            end
            CLEAR: begin
                slot_d[cap_idx_q] = cap_data_q;
                idx_d             = cap_idx_q;
                state_d           = LOAD;
            end
            LOAD: begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            idx_q      <= '0;
            cap_idx_q  <= '0;
            cap_data_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            cap_idx_q  <= cap_idx_d;
            cap_data_q <= cap_data_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign A1      = slot_q[0];
    assign A2      = slot_q[1];
    assign A3      = slot_q[2];
    assign A4      = slot_q[3];
    assign idx_out = idx_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign err     = err_q;

endmodule

// File: doc/slot_encoder.md
SLOT_ENCODER -- requirements
Module: slot_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the bit width of each slot and of data_in.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  load request, sampled on the rising edge of clk.
REQ-005 SHALL have port idx_in  input  2  target slot: 0 selects A1, 1 selects A2, 2 selects A3, 3 selects A4.
REQ-006 SHALL have port data_in  input  WIDTH  value to place in the target slot.
REQ-007 SHALL have port shift  input  1  rotate request; present in every build.
REQ-008 SHALL have ports A1, A2, A3, A4  output  WIDTH each  registered slots; at most one is nonzero.
REQ-009 SHALL have port idx_out  output  2  registered index of the slot that holds the data.
REQ-010 SHALL have port busy  output  1  high while a load is in progress.
REQ-011 SHALL have port valid  output  1  high when the slots hold a complete one-hot pattern.
REQ-012 SHALL have port err  output  1  one-cycle pulse when a load request is rejected.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, LOAD and HOLD.
REQ-014 SHALL accept start in IDLE or HOLD when data_in != 0.
- On acceptance, capture idx_in and data_in into internal registers.
- Zero A1..A4.
- Set busy=1 and valid=0.
- Go to CLEAR.
REQ-015 SHALL, in CLEAR, write the captured data into the slot selected by the captured index, set idx_out to that index, and go to LOAD.
REQ-016 SHALL, in LOAD, set busy=0 and valid=1 and go to HOLD; valid therefore rises at the third rising edge counting the accepting edge as the first.
REQ-017 SHALL, on start with data_in == 0 in IDLE or HOLD, pulse err=1 for exactly one cycle and leave the state, slots, idx_out and valid unchanged.
REQ-018 SHALL ignore start in CLEAR and LOAD: no err pulse, and no change to the captured values.
REQ-019 SHALL keep the slots stable in HOLD until the next accepted start, the next shift, or reset.
REQ-020 SHALL guarantee that the slots never have more than one nonzero value at any clock edge.
REQ-021 SHALL guarantee that, when valid=1, a one-hot-slot decoder on A1..A4 reports done=1 and an index equal to idx_out.

Reset
REQ-022 SHALL, while rst_n=0, immediately force the following regardless of clk:
- A1..A4 = 0, idx_out = 0;
- busy = 0, valid = 0, err = 0;
- FSM = IDLE, captured registers = 0.
REQ-023 SHALL abandon a load in progress when reset is asserted mid-load, and leave no partial slot contents.
REQ-024 SHALL leave reset on the first rising edge of clk after rst_n rises and act on start no earlier than that edge.

Configuration
REQ-025 SHALL compile rotation in only when the macro SLOT_ENCODER_ROTATE_EN is defined.
REQ-026 SHALL, with SLOT_ENCODER_ROTATE_EN defined, rotate on shift=1 sampled in HOLD:
- A1->A2, A2->A3, A3->A4, A4->A1 in one edge;
- idx_out increments modulo 4 (3 wraps to 0);
- valid stays 1.
REQ-027 SHALL, with SLOT_ENCODER_ROTATE_EN defined, give start priority over shift when both are sampled high in HOLD; a rejected start (data_in == 0) lets shift proceed.
REQ-028 SHALL ignore shift in IDLE, CLEAR and LOAD in every build.
REQ-029 SHALL, without SLOT_ENCODER_ROTATE_EN, ignore shift entirely, contain no rotation logic, and otherwise behave identically.

Verification
REQ-030 SHALL cover: reset, then start with idx_in=2, data_in=5'h13 -> busy high for 2 cycles, then A3=13, A1=A2=A4=0, idx_out=2, valid=1.
REQ-031 SHALL cover: start with data_in=0 in IDLE -> err=1 for one cycle; valid=0, all slots 0, FSM stays IDLE.
REQ-032 SHALL cover: start idx_in=1 data_in=7 during CLEAR of a prior load with idx_in=3 data_in=9 -> final A4=9, idx_out=3, no err pulse.
REQ-033 SHALL cover: in HOLD with A1=1, start idx_in=0 data_in=1F -> after the accepting edge all slots 0 and valid=0; two edges later A1=1F, valid=1.
REQ-034 SHALL cover (rotation build): from A4=6, idx_out=3, one shift -> A1=6, idx_out=0; shift and start (idx_in=2, data_in=4) together -> A3=4 after load, no rotation.
REQ-035 SHALL cover: rst_n dropped one cycle after start -> outputs go to 0 immediately with no clk edge, and stay 0 until the next start.
